// File: rtl/onchip_mem_arbiter_pkg.sv
// Shared definitions for the on-chip memory arbiter.
// Contents:
//   - arb_state_t         : arbiter state encoding (RUN / DRAIN / HALTED)
//   - REQ_REG/PAT/HOST    : requester index constants
//   - ARB_NUM_REQ         : default number of requesters
//   - ARB_MAX_OUTSTANDING : default read-tag FIFO depth
package onchip_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } arb_state_t;

  localparam int REQ_REG  = 0;  // register poll / update
  localparam int REQ_PAT  = 1;  // pattern fetch
  localparam int REQ_HOST = 2;  // host loader

  localparam int ARB_NUM_REQ         = 3;
  localparam int ARB_MAX_OUTSTANDING = 4;

endpackage

// File: rtl/arb_tag_fifo.sv
// Read-tag FIFO: remembers which requester issued each outstanding read so
// returning data can be steered back in issue order.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   i_push/i_push_data : enqueue a tag (accepted when not full, or when a pop
//                        happens in the same cycle)
//   i_pop           : dequeue the head (ignored when empty)
//   o_head          : current head tag
//   o_full/o_empty  : level flags
module arb_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_push_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  // A simultaneous pop frees the slot the push needs.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - CNT_W'(1);
    end
  end

  // Storage needs no reset: the pointers/count define which entries are live.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Round-robin arbiter between NUM_REQ requesters sharing one on-chip memory
// port, with in-order read-return steering and a drain/quiesce handshake.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   req_*               : packed per-requester request bundles (slot i at i*W)
//   req_ready           : one-hot grant
//   rsp_valid/rsp_data  : one-hot read-return strobe, shared read data
//   mem_*               : registered memory command / memory read return
//   drain_req/drain_done: quiesce handshake
//   err_unexpected_rsp  : sticky, read return seen with nothing outstanding
//   dbg_state           : current arbiter state
//
// Handshake: a request transfers in the cycle where req_valid[i] and
// req_ready[i] are both high; req_valid may be held across cycles and the
// requester must keep its request fields stable until it sees req_ready.
module onchip_mem_arbiter
  import onchip_mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ         = ARB_NUM_REQ,
  parameter int ADDR_W          = 13,
  parameter int DATA_W          = 256,
  parameter int MAX_OUTSTANDING = ARB_MAX_OUTSTANDING
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W/8-1:0] req_byte_enable,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_data,
  output logic                        mem_chip_select,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W/8-1:0]         mem_byte_enable,
  output logic [DATA_W-1:0]           mem_write_data,
  input  logic                        mem_read_valid,
  input  logic [DATA_W-1:0]           mem_read_data,
  input  logic                        drain_req,
  output logic                        drain_done,
  output logic                        err_unexpected_rsp,
  output arb_state_t                  dbg_state
);

  localparam int BE_W  = DATA_W / 8;
  localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t        r_state;
  arb_state_t        w_next_state;
  logic [TAG_W-1:0]  r_rr_ptr;
  logic              r_mem_cs;
  logic              r_mem_rd;
  logic              r_mem_wr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [BE_W-1:0]   r_mem_be;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_err;

  logic [NUM_REQ-1:0] w_grant;
  logic               w_gnt_found;
  logic [TAG_W-1:0]   w_gnt_idx;
  logic               w_gnt_write;
  logic [ADDR_W-1:0]  w_gnt_addr;
  logic [BE_W-1:0]    w_gnt_be;
  logic [DATA_W-1:0]  w_gnt_wdata;
  logic               w_grant_en;
  logic               w_read_ok;
  logic               w_push;
  logic               w_pop;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [TAG_W-1:0]   w_fifo_head;

  // Grants only in RUN; rst is folded in so req_ready drops without a clock.
  assign w_grant_en = (r_state == ST_RUN) && !rst;
  assign w_pop      = mem_read_valid && !w_fifo_empty;
  // A return popping this cycle frees a slot for a read granted this cycle.
  assign w_read_ok  = !w_fifo_full || w_pop;

  // Search starts one past the last grant; r_rr_ptr holds the last grant.
  always_comb begin
    int idx;
    idx         = 0;
    w_grant     = '0;
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (w_grant_en && !w_gnt_found && req_valid[idx] &&
          (req_write[idx] || w_read_ok)) begin
        w_gnt_found  = 1'b1;
        w_gnt_idx    = TAG_W'(idx);
        w_grant[idx] = 1'b1;
      end
    end
  end

  assign req_ready   = w_grant;
  assign w_gnt_write = req_write[w_gnt_idx];
  assign w_gnt_addr  = req_addr[w_gnt_idx*ADDR_W +: ADDR_W];
  assign w_gnt_be    = req_byte_enable[w_gnt_idx*BE_W +: BE_W];
  assign w_gnt_wdata = req_wdata[w_gnt_idx*DATA_W +: DATA_W];
  assign w_push      = w_gnt_found && !w_gnt_write;

  arb_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .W     (TAG_W)
  ) u_tag_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (w_gnt_idx),
    .i_pop       (w_pop),
    .o_head      (w_fifo_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

  // Return steering: reset empties the FIFO, so no strobe can leak in reset.
  always_comb begin
    rsp_valid = '0;
    if (w_pop) rsp_valid[w_fifo_head] = 1'b1;
  end
  assign rsp_data = mem_read_data;

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_RUN:    if (drain_req) w_next_state = ST_DRAIN;
      ST_DRAIN:  if (w_fifo_empty && !r_mem_cs) w_next_state = ST_HALTED;
      ST_HALTED: if (!drain_req) w_next_state = ST_RUN;
      default:   w_next_state = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_rr_ptr    <= TAG_W'(NUM_REQ - 1);
      r_mem_cs    <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= '0;
      r_mem_wdata <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_mem_cs    <= w_gnt_found;
      r_mem_rd    <= w_gnt_found && !w_gnt_write;
      r_mem_wr    <= w_gnt_found && w_gnt_write;
      r_mem_addr  <= w_gnt_found ? w_gnt_addr : '0;
      r_mem_be    <= (w_gnt_found && w_gnt_write) ? w_gnt_be : '0;
      r_mem_wdata <= (w_gnt_found && w_gnt_write) ? w_gnt_wdata : '0;
      if (w_gnt_found) r_rr_ptr <= w_gnt_idx;
      if (mem_read_valid && w_fifo_empty) r_err <= 1'b1;
    end
  end

  assign mem_chip_select    = r_mem_cs;
  assign mem_read           = r_mem_rd;
  assign mem_write          = r_mem_wr;
  assign mem_addr           = r_mem_addr;
  assign mem_byte_enable    = r_mem_be;
  assign mem_write_data     = r_mem_wdata;
  // r_state is a flop, so this output is registered and high only in HALTED.
  assign drain_done         = (r_state == ST_HALTED);
  assign err_unexpected_rsp = r_err;
  assign dbg_state          = r_state;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
module tb_onchip_mem_arbiter;
  import onchip_mem_arbiter_pkg::*;

  localparam int NR = 3;
  localparam int AW = 13;
  localparam int DW = 256;
  localparam int BW = DW / 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_valid = '0;
  logic [NR-1:0]    req_write = '0;
  logic [NR*AW-1:0] req_addr  = '0;
  logic [NR*BW-1:0] req_be    = '0;
  logic [NR*DW-1:0] req_wdata = '0;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_data;
  logic             mem_cs, mem_read, mem_write;
  logic [AW-1:0]    mem_addr;
  logic [BW-1:0]    mem_be;
  logic [DW-1:0]    mem_wdata;
  logic             man_rv = 1'b0;
  logic [DW-1:0]    man_rd = '0;
  logic             drain_req = 1'b0;
  logic             drain_done;
  logic             err;
  arb_state_t       dbg_state;

  onchip_mem_arbiter dut (
    .clk                (clk),
    .rst                (rst),
    .req_valid          (req_valid),
    .req_write          (req_write),
    .req_addr           (req_addr),
    .req_byte_enable    (req_be),
    .req_wdata          (req_wdata),
    .req_ready          (req_ready),
    .rsp_valid          (rsp_valid),
    .rsp_data           (rsp_data),
    .mem_chip_select    (mem_cs),
    .mem_read           (mem_read),
    .mem_write          (mem_write),
    .mem_addr           (mem_addr),
    .mem_byte_enable    (mem_be),
    .mem_write_data     (mem_wdata),
    .mem_read_valid     (man_rv),
    .mem_read_data      (man_rd),
    .drain_req          (drain_req),
    .drain_done         (drain_done),
    .err_unexpected_rsp (err),
    .dbg_state          (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int oh_idx(input logic [2:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [AW-1:0] addr_of(input int i);
    return AW'(32'h100 + i);
  endfunction

  function automatic logic [BW-1:0] be_of(input int i);
    return BW'(32'hF << (4 * i));
  endfunction

  function automatic logic [DW-1:0] wd_of(input int i);
    return {8{32'(32'hA000_0000 + i)}};
  endfunction

  function automatic logic [DW-1:0] mkdata(input int k);
    return {8{32'(32'hD000_0000 + k)}};
  endfunction

  task automatic set_defaults();
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW]  = addr_of(i);
      req_be[i*BW +: BW]    = be_of(i);
      req_wdata[i*DW +: DW] = wd_of(i);
    end
  endtask

  task automatic ret(input int k);
    man_rv = 1'b1;
    man_rd = mkdata(k);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0] valid;
    logic [2:0] exp_ready;
  } vec_t;

  vec_t tbl [15];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] prev;
    int gi;

    // Round-robin over write requests (writes never touch the tag FIFO).
    tbl[0]  = '{3'b111, 3'b001};
    tbl[1]  = '{3'b111, 3'b010};
    tbl[2]  = '{3'b111, 3'b100};
    tbl[3]  = '{3'b111, 3'b001};
    tbl[4]  = '{3'b111, 3'b010};
    tbl[5]  = '{3'b111, 3'b100};
    tbl[6]  = '{3'b000, 3'b000};
    tbl[7]  = '{3'b010, 3'b010};
    tbl[8]  = '{3'b011, 3'b001};
    tbl[9]  = '{3'b101, 3'b100};
    tbl[10] = '{3'b110, 3'b010};
    tbl[11] = '{3'b001, 3'b001};
    tbl[12] = '{3'b001, 3'b001};
    tbl[13] = '{3'b110, 3'b010};
    tbl[14] = '{3'b000, 3'b000};

    set_defaults();
    #2;
    chk("reset_mem_cs",   256'(mem_cs), 256'(0));
    chk("reset_ready",    256'(req_ready), 256'(0));
    chk("reset_rsp",      256'(rsp_valid), 256'(0));
    chk("reset_done",     256'(drain_done), 256'(0));
    chk("reset_err",      256'(err), 256'(0));
    chk("reset_state",    256'(dbg_state), 256'(ST_RUN));
    tick();
    tick();
    rst = 1'b0;

    // ---- table-driven round-robin (scenario 1 in rows 0..5) ----
    prev = '0;
    for (int n = 0; n < 15; n++) begin
      req_valid = tbl[n].valid;
      req_write = 3'b111;
      #1;
      chk($sformatf("rr_ready[%0d]", n), 256'(req_ready), 256'(tbl[n].exp_ready));
      if (prev != 3'b000) begin
        gi = oh_idx(prev);
        chk($sformatf("rr_cs[%0d]", n),    256'(mem_cs), 256'(1));
        chk($sformatf("rr_wr[%0d]", n),    256'(mem_write), 256'(1));
        chk($sformatf("rr_addr[%0d]", n),  256'(mem_addr), 256'(addr_of(gi)));
        chk($sformatf("rr_be[%0d]", n),    256'(mem_be), 256'(be_of(gi)));
        chk($sformatf("rr_wdata[%0d]", n), mem_wdata, wd_of(gi));
      end else begin
        chk($sformatf("rr_idle_cs[%0d]", n), 256'(mem_cs), 256'(0));
        chk($sformatf("rr_idle_be[%0d]", n), 256'(mem_be), 256'(0));
      end
      prev = tbl[n].exp_ready;
      tick();
    end

    // ---- scenario 2: 5 back-to-back reads from requester 1, delayed returns ----
    req_write = 3'b000;
    req_valid = 3'b010;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("s2_grant[%0d]", k), 256'(req_ready), 256'(3'b010));
      if (k > 0) begin
        chk($sformatf("s2_mem_read[%0d]", k), 256'(mem_read), 256'(1));
        chk($sformatf("s2_mem_be[%0d]", k),   256'(mem_be), 256'(0));
      end
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("s2_full_block[%0d]", k), 256'(req_ready), 256'(3'b000));
      tick();
    end
    ret(0);
    #1;
    chk("s2_grant5_on_return", 256'(req_ready), 256'(3'b010));
    chk("s2_rsp_valid[0]",     256'(rsp_valid), 256'(3'b010));
    chk("s2_rsp_data[0]",      rsp_data, mkdata(0));
    tick();
    req_valid = 3'b000;
    for (int k = 1; k < 5; k++) begin
      ret(k);
      #1;
      chk($sformatf("s2_rsp_valid[%0d]", k), 256'(rsp_valid), 256'(3'b010));
      chk($sformatf("s2_rsp_data[%0d]", k),  rsp_data, mkdata(k));
      tick();
    end
    man_rv = 1'b0;
    #1;
    chk("s2_rsp_idle", 256'(rsp_valid), 256'(0));
    chk("s2_no_err",   256'(err), 256'(0));
    tick();

    // ---- scenario 4: drain with 2 reads outstanding (tags 2 then 0) ----
    req_valid = 3'b101;
    #1;
    chk("s4_grant_r2", 256'(req_ready), 256'(3'b100));
    tick();
    #1;
    chk("s4_grant_r0", 256'(req_ready), 256'(3'b001));
    tick();
    req_valid = 3'b000;
    drain_req = 1'b1;
    #1;
    chk("s4_mem_read", 256'(mem_read), 256'(1));
    tick();
    req_valid = 3'b111;
    #1;
    chk("s4_no_grant_drain", 256'(req_ready), 256'(0));
    chk("s4_state_drain",    256'(dbg_state), 256'(ST_DRAIN));
    chk("s4_done_low",       256'(drain_done), 256'(0));
    tick();
    ret(20);
    #1;
    chk("s4_rsp_tag2",  256'(rsp_valid), 256'(3'b100));
    chk("s4_rsp_data2", rsp_data, mkdata(20));
    chk("s4_no_grant2", 256'(req_ready), 256'(0));
    tick();
    ret(21);
    #1;
    chk("s4_rsp_tag0",  256'(rsp_valid), 256'(3'b001));
    chk("s4_rsp_data0", rsp_data, mkdata(21));
    tick();
    man_rv = 1'b0;
    #1;
    chk("s4_done_not_yet", 256'(drain_done), 256'(0));
    tick();
    #1;
    chk("s4_done",          256'(drain_done), 256'(1));
    chk("s4_state_halted",  256'(dbg_state), 256'(ST_HALTED));
    chk("s4_no_grant_halt", 256'(req_ready), 256'(0));
    tick();
    drain_req = 1'b0;
    #1;
    chk("s4_done_held", 256'(drain_done), 256'(1));
    chk("s4_halt_nogr", 256'(req_ready), 256'(0));
    tick();
    req_write = 3'b111;
    #1;
    chk("s4_done_clear", 256'(drain_done), 256'(0));
    chk("s4_resume",     256'(req_ready), 256'(3'b010));
    tick();
    req_valid = 3'b000;
    tick();

    // ---- scenario 3: FIFO full of reads, write from requester 2 still granted ----
    req_write = 3'b000;
    req_valid = 3'b010;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("s3_fill[%0d]", k), 256'(req_ready), 256'(3'b010));
      tick();
    end
    req_valid = 3'b110;
    req_write = 3'b100;
    req_addr[2*AW +: AW] = 13'h0010;
    req_be[2*BW +: BW]   = 32'h4000_0000;
    #1;
    chk("s3_write_grant", 256'(req_ready), 256'(3'b100));
    tick();
    req_valid = 3'b010;
    #1;
    chk("s3_blocked",  256'(req_ready), 256'(0));
    chk("s3_cs",       256'(mem_cs), 256'(1));
    chk("s3_mem_wr",   256'(mem_write), 256'(1));
    chk("s3_mem_rd",   256'(mem_read), 256'(0));
    chk("s3_mem_addr", 256'(mem_addr), 256'(13'h0010));
    chk("s3_mem_be",   256'(mem_be), 256'(32'h4000_0000));
    tick();
    req_valid = 3'b000;
    set_defaults();
    for (int k = 0; k < 4; k++) begin
      ret(30 + k);
      #1;
      chk($sformatf("s3_rsp[%0d]", k), 256'(rsp_valid), 256'(3'b010));
      tick();
    end
    man_rv = 1'b0;

    // ---- scenario 5: unexpected return ----
    ret(40);
    #1;
    chk("s5_no_rsp",     256'(rsp_valid), 256'(0));
    chk("s5_err_before", 256'(err), 256'(0));
    tick();
    man_rv = 1'b0;
    #1;
    chk("s5_err_set", 256'(err), 256'(1));
    tick();
    tick();
    tick();
    #1;
    chk("s5_err_sticky", 256'(err), 256'(1));
    // The FIFO must still be empty: one read, one return, tag 0.
    req_valid = 3'b001;
    req_write = 3'b000;
    #1;
    chk("s5_read_grant", 256'(req_ready), 256'(3'b001));
    tick();
    req_valid = 3'b000;
    tick();
    ret(41);
    #1;
    chk("s5_rsp_tag0", 256'(rsp_valid), 256'(3'b001));
    chk("s5_rsp_data", rsp_data, mkdata(41));
    tick();
    man_rv = 1'b0;

    // ---- scenario 6: async reset with 3 reads outstanding ----
    req_valid = 3'b111;
    #1;
    chk("s6_grant_a", 256'(req_ready), 256'(3'b010));
    tick();
    #1;
    chk("s6_grant_b", 256'(req_ready), 256'(3'b100));
    tick();
    #1;
    chk("s6_grant_c", 256'(req_ready), 256'(3'b001));
    tick();
    #1;
    chk("s6_pre_rd", 256'(mem_read), 256'(1));
    #1;
    rst = 1'b1;
    #1;
    chk("s6_cs",    256'(mem_cs), 256'(0));
    chk("s6_rd",    256'(mem_read), 256'(0));
    chk("s6_wr",    256'(mem_write), 256'(0));
    chk("s6_addr",  256'(mem_addr), 256'(0));
    chk("s6_be",    256'(mem_be), 256'(0));
    chk("s6_wdata", mem_wdata, 256'(0));
    chk("s6_ready", 256'(req_ready), 256'(0));
    chk("s6_rsp",   256'(rsp_valid), 256'(0));
    chk("s6_done",  256'(drain_done), 256'(0));
    chk("s6_err",   256'(err), 256'(0));
    chk("s6_state", 256'(dbg_state), 256'(ST_RUN));
    tick();
    tick();
    rst = 1'b0;
    req_write = 3'b111;
    #1;
    chk("s6_ptr_reset", 256'(req_ready), 256'(3'b001));
    tick();
    req_valid = 3'b000;
    ret(50);
    #1;
    chk("s6_stale_no_rsp", 256'(rsp_valid), 256'(0));
    tick();
    man_rv = 1'b0;
    #1;
    chk("s6_stale_err", 256'(err), 256'(1));
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
